// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester data-memory arbiter.
// Holds the FSM state encoding, requester-id width and the address-check helper.
package mem_arb_pkg;

  localparam int unsigned MEM_BYTES_DEFAULT = 4096;
  localparam int unsigned REQ_ID_W          = 1;

  typedef logic [REQ_ID_W-1:0] req_id_t;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  // A word access is rejected when misaligned or when it would run past the last word.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned mem_bytes);
    return (addr[1:0] != 2'b00) || (addr > 32'(mem_bytes - 4));
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker: a sole requester wins; on a tie the requester
// that was not granted last wins. Output is one-hot (or zero when idle).
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [1:0] i_valid,
  input  req_id_t    i_last_grant,
  output logic [1:0] o_grant
);

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    o_grant = 2'b00;
    case (i_valid)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = (i_last_grant == req_id_t'(1)) ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two load/store requesters onto one combinational-read data memory.
// Each accepted request spends one cycle in ACCESS and returns a one-cycle response.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        req0_valid,
  input  logic        req0_write,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        req0_ready,
  output logic        resp0_valid,
  output logic [31:0] resp0_rdata,
  output logic        resp0_err,

  input  logic        req1_valid,
  input  logic        req1_write,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        req1_ready,
  output logic        resp1_valid,
  output logic [31:0] resp1_rdata,
  output logic        resp1_err,

  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_t      r_state;
  state_t      w_next_state;
  req_id_t     r_last_grant;
  req_id_t     r_owner;
  logic        r_write;
  logic        r_err;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic [1:0]  r_resp_valid;
  logic [1:0]  r_resp_err;
  logic [31:0] r_resp_rdata [2];

  logic [1:0]  w_valid;
  logic [1:0]  w_grant;
  logic [1:0]  w_ready;
  logic        w_idle;
  logic        w_accept;
  req_id_t     w_grant_id;
  logic        w_sel_write;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;

  assign w_valid = {req1_valid, req0_valid};

  rr_arbiter2 u_rr (
    .i_valid      (w_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  // Ready is also masked by rst so every output reads 0 while reset is held.
  assign w_idle     = (r_state == S_IDLE) && !rst;
  assign w_ready    = w_idle ? w_grant : 2'b00;
  assign w_accept   = |w_ready;
  assign w_grant_id = req_id_t'(w_ready[1]);

  assign w_sel_write = w_ready[1] ? req1_write : req0_write;
  assign w_sel_addr  = w_ready[1] ? req1_addr  : req0_addr;
  assign w_sel_wdata = w_ready[1] ? req1_wdata : req0_wdata;

  assign req0_ready  = w_ready[0];
  assign req1_ready  = w_ready[1];

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next_state = S_ACCESS;
      S_ACCESS: w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    if (r_state == S_ACCESS && !r_err) begin
      mem_read    = !r_write;
      mem_write   = r_write;
      mem_address = r_addr;
      mem_wdata   = r_wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement or process order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= req_id_t'(1);
      r_owner      <= '0;
      r_write      <= 1'b0;
      r_err        <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_last_grant <= w_grant_id;
        r_owner      <= w_grant_id;
        r_write      <= w_sel_write;
        r_addr       <= w_sel_addr;
        r_wdata      <= w_sel_wdata;
        r_err        <= addr_err(w_sel_addr, MEM_BYTES);
      end
    end
  end

  // Responses are single-cycle pulses registered at the edge that ends ACCESS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resp_valid    <= '0;
      r_resp_err      <= '0;
      r_resp_rdata[0] <= '0;
      r_resp_rdata[1] <= '0;
    end else begin
      r_resp_valid    <= '0;
      r_resp_err      <= '0;
      r_resp_rdata[0] <= '0;
      r_resp_rdata[1] <= '0;
      if (r_state == S_ACCESS) begin
        r_resp_valid[r_owner] <= 1'b1;
        r_resp_err[r_owner]   <= r_err;
        r_resp_rdata[r_owner] <= (!r_err && !r_write) ? mem_rdata : 32'h0;
      end
    end
  end

  assign resp0_valid = r_resp_valid[0];
  assign resp0_err   = r_resp_err[0];
  assign resp0_rdata = r_resp_rdata[0];
  assign resp1_valid = r_resp_valid[1];
  assign resp1_err   = r_resp_err[1];
  assign resp1_rdata = r_resp_rdata[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural 4 KiB memory.
// Memory word i starts at 32'hA5A5_0000 | i so every load has a known value.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_write = '0;
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  wire  [1:0]  req_ready;
  wire  [1:0]  resp_valid;
  wire  [1:0]  resp_err;
  wire  [31:0] resp_rdata [2];
  wire         mem_read;
  wire         mem_write;
  wire  [31:0] mem_address;
  wire  [31:0] mem_wdata;
  wire  [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;

  logic [31:0] mem_model [1024];
  logic        mem_loaded = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_BYTES(4096)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req_valid[0]),
    .req0_write  (req_write[0]),
    .req0_addr   (req_addr[0]),
    .req0_wdata  (req_wdata[0]),
    .req0_ready  (req_ready[0]),
    .resp0_valid (resp_valid[0]),
    .resp0_rdata (resp_rdata[0]),
    .resp0_err   (resp_err[0]),
    .req1_valid  (req_valid[1]),
    .req1_write  (req_write[1]),
    .req1_addr   (req_addr[1]),
    .req1_wdata  (req_wdata[1]),
    .req1_ready  (req_ready[1]),
    .resp1_valid (resp_valid[1]),
    .resp1_rdata (resp_rdata[1]),
    .resp1_err   (resp_err[1]),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  assign mem_rdata = mem_model[mem_address[11:2]];

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 1024; i++) mem_model[i] <= 32'hA5A5_0000 | 32'(i);
      mem_loaded <= 1'b1;
    end else if (mem_write) begin
      mem_model[mem_address[11:2]] <= mem_wdata;
      wr_count <= wr_count + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    rst = 1'b1;
    req_valid = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Issues one request and reports what the DUT did; the caller does the comparisons.
  task automatic do_req(input int id, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rdata,
                        output logic err, output int lat, output logic mrd,
                        output logic mwr, output logic [31:0] maddr,
                        output logic [31:0] mwd, output logic timed_out);
    int waited;
    timed_out = 1'b0; rdata = '0; err = 1'b0; lat = 0;
    mrd = 1'b0; mwr = 1'b0; maddr = '0; mwd = '0;
    @(negedge clk);
    req_valid[id] = 1'b1; req_write[id] = wr; req_addr[id] = addr; req_wdata[id] = wd;
    #1;
    waited = 0;
    while (!req_ready[id] && waited < 8) begin
      @(negedge clk); #1; waited++;
    end
    if (!req_ready[id]) begin
      timed_out = 1'b1; req_valid[id] = 1'b0; return;
    end
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    mrd = mem_read; mwr = mem_write; maddr = mem_address; mwd = mem_wdata;
    // Cycle 0 is the cycle ready was high; the response should land in cycle 2.
    lat = 1;
    while (!resp_valid[id] && lat < 8) begin
      @(posedge clk); #1; lat++;
    end
    if (!resp_valid[id]) begin
      timed_out = 1'b1; return;
    end
    rdata = resp_rdata[id]; err = resp_err[id];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_addr[0] = 32'h0; req_addr[1] = 32'h0; req_wdata[0] = 32'h0; req_wdata[1] = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    req_valid = 2'b01;
    #1;
    checks++;
    if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", req_ready); end
    checks++;
    if ({resp_valid, resp_err, mem_read, mem_write} !== 6'b0) begin
      errors++; $display("FAIL reset_outputs: got %b want 000000", {resp_valid, resp_err, mem_read, mem_write});
    end
    checks++;
    if (mem_address !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_mem_bus: got addr %h wdata %h want 0", mem_address, mem_wdata);
    end
    req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL first_tie: got %b want 01", req_ready); end
    req_valid = 2'b00;
    #1;
  endtask

  task automatic test_store_load();
    logic [31:0] rd, ma, mw; logic er, mr, mwe, to; int lat;
    do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat, mr, mwe, ma, mw, to);
    checks++;
    if (to || lat != 2) begin errors++; $display("FAIL store_latency: got %0d timeout %0d want 2", lat, to); end
    checks++;
    if ({mr, mwe} !== 2'b01 || ma !== 32'h10 || mw !== 32'hDEADBEEF) begin
      errors++; $display("FAIL store_bus: got rd %b wr %b addr %h wdata %h want 0 1 10 deadbeef", mr, mwe, ma, mw);
    end
    checks++;
    if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL store_resp: got err %b rdata %h want 0 0", er, rd); end
    do_req(0, 1'b0, 32'h10, 32'h0, rd, er, lat, mr, mwe, ma, mw, to);
    checks++;
    if (to || lat != 2) begin errors++; $display("FAIL load_latency: got %0d timeout %0d want 2", lat, to); end
    checks++;
    if ({mr, mwe} !== 2'b10 || ma !== 32'h10) begin
      errors++; $display("FAIL load_bus: got rd %b wr %b addr %h want 1 0 10", mr, mwe, ma);
    end
    checks++;
    if (er !== 1'b0 || rd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL load_resp: got err %b rdata %h want 0 deadbeef", er, rd);
    end
  endtask

  task automatic test_round_robin();
    int gq[$]; int rq[$]; logic [31:0] dq[$];
    int both_ready = 0; int both_resp = 0;
    apply_reset();
    req_write = 2'b00;
    req_addr[0] = 32'h100; req_addr[1] = 32'h104;
    req_valid = 2'b11;
    #1;
    for (int c = 0; c < 12; c++) begin
      if (req_ready == 2'b11) both_ready++;
      if (req_ready[0]) gq.push_back(0);
      else if (req_ready[1]) gq.push_back(1);
      @(posedge clk); #1;
      if (resp_valid == 2'b11) both_resp++;
      if (resp_valid[0]) begin rq.push_back(0); dq.push_back(resp_rdata[0]); end
      else if (resp_valid[1]) begin rq.push_back(1); dq.push_back(resp_rdata[1]); end
      @(negedge clk); #1;
    end
    req_valid = 2'b00;
    repeat (2) begin
      @(posedge clk); #1;
      if (resp_valid != 2'b00) rq.push_back(9);
    end
    checks++;
    if (both_ready != 0 || both_resp != 0) begin
      errors++; $display("FAIL rr_exclusive: got %0d dual-ready %0d dual-resp cycles want 0", both_ready, both_resp);
    end
    checks++;
    if (gq.size() != 6 || rq.size() != 6) begin
      errors++; $display("FAIL rr_counts: got %0d grants %0d resps want 6 6", gq.size(), rq.size());
    end
    for (int i = 0; i < 6 && i < gq.size() && i < rq.size(); i++) begin
      checks++;
      if (gq[i] != i % 2 || rq[i] != i % 2) begin
        errors++; $display("FAIL rr_order[%0d]: got grant %0d resp %0d want %0d", i, gq[i], rq[i], i % 2);
      end
      checks++;
      if (dq[i] !== ((i % 2) ? 32'hA5A5_0041 : 32'hA5A5_0040)) begin
        errors++; $display("FAIL rr_data[%0d]: got %h want %h", i, dq[i], (i % 2) ? 32'hA5A5_0041 : 32'hA5A5_0040);
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd, ma, mw; logic er, mr, mwe, to; int lat; int wc;
    do_req(0, 1'b0, 32'h13, 32'h0, rd, er, lat, mr, mwe, ma, mw, to);
    checks++;
    if (to || er !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL err_misaligned: got err %b rdata %h timeout %0d want 1 0 0", er, rd, to);
    end
    checks++;
    if ({mr, mwe} !== 2'b00 || ma !== 32'h0) begin
      errors++; $display("FAIL err_misaligned_bus: got rd %b wr %b addr %h want 0 0 0", mr, mwe, ma);
    end
    do_req(1, 1'b0, 32'h1000, 32'h0, rd, er, lat, mr, mwe, ma, mw, to);
    checks++;
    if (to || er !== 1'b1 || rd !== 32'h0 || {mr, mwe} !== 2'b00) begin
      errors++; $display("FAIL err_range_load: got err %b rdata %h rd %b wr %b want 1 0 0 0", er, rd, mr, mwe);
    end
    wc = wr_count;
    do_req(1, 1'b1, 32'h1000, 32'h55AA55AA, rd, er, lat, mr, mwe, ma, mw, to);
    checks++;
    if (to || er !== 1'b1 || mwe !== 1'b0 || wr_count != wc) begin
      errors++; $display("FAIL err_range_store: got err %b wr %b writes %0d want 1 0 %0d", er, mwe, wr_count, wc);
    end
  endtask

  task automatic test_boundary();
    logic [31:0] rd, ma, mw; logic er, mr, mwe, to; int lat;
    do_req(1, 1'b0, 32'hFFC, 32'h0, rd, er, lat, mr, mwe, ma, mw, to);
    checks++;
    if (to || er !== 1'b0 || rd !== 32'hA5A5_03FF) begin
      errors++; $display("FAIL last_word: got err %b rdata %h want 0 a5a503ff", er, rd);
    end
    do_req(1, 1'b0, 32'hFFD, 32'h0, rd, er, lat, mr, mwe, ma, mw, to);
    checks++;
    if (to || er !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL past_last_word: got err %b rdata %h want 1 0", er, rd);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd, ma, mw; logic er, mr, mwe, to; int lat; int wc; int waited; int stray;
    wc = wr_count;
    stray = 0;
    @(negedge clk);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h20; req_wdata[0] = 32'hCAFEF00D;
    #1;
    waited = 0;
    while (!req_ready[0] && waited < 8) begin @(negedge clk); #1; waited++; end
    checks++;
    if (!req_ready[0]) begin errors++; $display("FAIL abort_accept: got ready 0 want 1"); end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    checks++;
    if (mem_write !== 1'b1) begin errors++; $display("FAIL abort_pre: got mem_write %b want 1", mem_write); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (mem_write !== 1'b0 || mem_read !== 1'b0) begin
      errors++; $display("FAIL abort_drop: got mem_write %b mem_read %b want 0 0", mem_write, mem_read);
    end
    repeat (3) begin
      @(posedge clk); #1;
      if (resp_valid != 2'b00) stray++;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (resp_valid != 2'b00) stray++;
    end
    checks++;
    if (stray != 0 || wr_count != wc) begin
      errors++; $display("FAIL abort_effects: got %0d responses %0d writes want 0 0", stray, wr_count - wc);
    end
    do_req(0, 1'b0, 32'h20, 32'h0, rd, er, lat, mr, mwe, ma, mw, to);
    checks++;
    if (to || er !== 1'b0 || rd !== 32'hA5A5_0008) begin
      errors++; $display("FAIL abort_reload: got err %b rdata %h want 0 a5a50008", er, rd);
    end
  endtask

  task automatic test_cancel();
    logic [31:0] rd, ma, mw; logic er, mr, mwe, to; int lat; int wc; int r0; int r1;
    wc = wr_count; r0 = 0; r1 = 0;
    @(negedge clk);
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 32'h30;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL cancel_grant0: got %b want 01", req_ready); end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = 32'h34; req_wdata[1] = 32'h12345678;
    @(negedge clk); #1;
    checks++;
    if (req_ready[1] !== 1'b0) begin errors++; $display("FAIL cancel_wait: got ready1 %b want 0", req_ready[1]); end
    req_valid[1] = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (resp_valid[0]) r0++;
      if (resp_valid[1]) r1++;
    end
    checks++;
    if (r0 != 1 || r1 != 0 || wr_count != wc) begin
      errors++; $display("FAIL cancel_effects: got resp0 %0d resp1 %0d writes %0d want 1 0 0", r0, r1, wr_count - wc);
    end
    do_req(0, 1'b0, 32'h34, 32'h0, rd, er, lat, mr, mwe, ma, mw, to);
    checks++;
    if (to || rd !== 32'hA5A5_000D) begin
      errors++; $display("FAIL cancel_reload: got rdata %h want a5a5000d", rd);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_round_robin();
    test_errors();
    test_boundary();
    test_reset_abort();
    test_cancel();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: MEM_BYTES, 4096, byte size of the shared data memory; legal word addresses are 0..MEM_BYTES-4.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-high; ports clk and rst.
REQ-003 clk  in  1  clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 reqN_valid  in  1  requester N (N=0,1) presents a request.
REQ-006 reqN_write  in  1  1=store word, 0=load word.
REQ-007 reqN_addr  in  32  byte address of the word access.
REQ-008 reqN_wdata  in  32  store data.
REQ-009 reqN_ready  out  1  request accepted this cycle (transfer on valid&ready).
REQ-010 respN_valid  out  1  one-cycle response pulse.
REQ-011 respN_rdata  out  32  load data; 0 for stores and errors.
REQ-012 respN_err  out  1  request rejected (misaligned or out of range).
REQ-013 mem_read, mem_write  out  1 each  data-memory read and write enables.
REQ-014 mem_address, mem_wdata  out  32 each  data-memory address and store data.
REQ-015 mem_rdata  in  32  combinational data-memory read data.

Function
REQ-016 FSM states IDLE and ACCESS; IDLE->ACCESS on any accepted request; ACCESS->IDLE unconditionally.
REQ-017 Accept only in IDLE; reqN_ready combinational, high only for the arbitration winner in IDLE, never both high.
REQ-018 Round-robin: sole valid requester wins; both valid -> requester not granted last wins; last_grant updates on every accept.
REQ-019 On accept, latch owner, write, addr and wdata, and err = (addr[1:0]!=0) | (addr > MEM_BYTES-4).
REQ-020 In ACCESS with err=0: mem_address=latched addr; mem_write=latched write; mem_read=!latched write; mem_wdata=latched wdata.
REQ-021 In ACCESS with err=1, and always in IDLE: mem_read=0, mem_write=0, mem_address=0, mem_wdata=0.
REQ-022 End of ACCESS: register respOWNER_valid=1, rdata=mem_rdata for non-error loads else 0, err=latched err; the other requester's response stays 0.
REQ-023 Latency: accept at edge N, memory access during cycle N..N+1, respN_valid high for exactly the cycle after edge N+1.
REQ-024 Throughput: one access per 2 cycles; a new accept may coincide with a response pulse.
REQ-025 A requester keeps valid and payload stable until ready; valid dropped before ready is a legal cancel.
REQ-026 Requester not granted sees ready=0 and waits; bounded wait of one access under contention.
REQ-027 Write occurs at the clock edge ending ACCESS; a load issued after a store to the same address returns the stored data.

Reset
REQ-028 rst asserted: state=IDLE, last_grant=1 (requester 0 wins first tie), all outputs 0, latched request cleared.
REQ-029 rst asserted during ACCESS aborts the access: mem_write drops immediately, no write occurs, no response issued.

Structure
REQ-030 Shared package mem_arb_pkg holds the state enum, MEM_BYTES default, and requester-id width.
REQ-031 The round-robin picker is a sub-module rr_arbiter2 (inputs two valids, last_grant; outputs one-hot grant).

Verification
REQ-032 Store 0xDEADBEEF at 0x10 by req0, then load 0x10 -> resp0 rdata=0xDEADBEEF, err=0, resp exactly 2 cycles after each accept.
REQ-033 Both valid continuously for 6 accesses from reset -> grant order 0,1,0,1,0,1; each resp only on the owner.
REQ-034 Load at 0x13 and at 0x1000 -> respN_err=1, rdata=0, mem_read and mem_write stay 0.
REQ-035 Load at 0xFFC (MEM_BYTES=4096) -> err=0, valid data; load at 0xFFD -> err=1.
REQ-036 Assert rst in ACCESS of a store to 0x20 -> no response, subsequent load of 0x20 returns its prior value.
REQ-037 req1 drops valid before ready while req0 is served -> no access or response for req1.
